// File: rtl/bcd_operand_loader_if.sv
// Operand-entry bus: switch/button inputs toward the loader and the packed
// operand word plus status flags back toward the adder/display side.
interface bcd_operand_loader_if;
   logic [3:0] SW;
   logic       CinSw;
   logic       Load;
   logic       Clr;
   logic [8:0] OPS;
   logic       Valid;
   logic       Err;
   logic [1:0] Stage;

   // Driver of switches/buttons, consumer of operands.
   modport master (
      output SW,
      output CinSw,
      output Load,
      output Clr,
      input  OPS,
      input  Valid,
      input  Err,
      input  Stage
   );

   // The loader itself.
   modport slave (
      input  SW,
      input  CinSw,
      input  Load,
      input  Clr,
      output OPS,
      output Valid,
      output Err,
      output Stage
   );
endinterface

// File: rtl/bcd_operand_loader.sv
// Sequential BCD operand entry: synchronizes and debounces the Load button,
// range-checks each digit and assembles a stable {Cin, A, B} word with a
// Valid flag for the downstream BCD adder.
module bcd_operand_loader #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic                 CLOCK_50,
   input  logic                 Reset,
   bcd_operand_loader_if.slave  bus
);

   typedef enum logic [1:0] {
      StA    = 2'b00,
      StB    = 2'b01,
      StDone = 2'b10
   } state_t;

   logic             r_s1;
   logic             r_s2;
   logic             r_lvl;
   logic             r_lvl_q;
   logic [CNT_W-1:0] r_cnt;

   state_t     r_state;
   logic [3:0] r_a;
   logic [3:0] r_b;
   logic       r_cin;
   logic       r_err;

   state_t     w_state_d;
   logic [3:0] w_a_d;
   logic [3:0] w_b_d;
   logic       w_cin_d;
   logic       w_err_d;

   logic w_accept;
   logic w_digit_ok;

   // Two-flop synchronizer, debounce counter and level-delay for edge detect.
   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_lvl   <= 1'b0;
         r_lvl_q <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_s1    <= bus.Load;
         r_s2    <= r_s1;
         r_lvl_q <= r_lvl;
         if (r_s2 != r_lvl) begin
            // The edge that would bring the count to DEBOUNCE_CYCLES flips the level.
            if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               r_lvl <= ~r_lvl;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign w_accept   = r_lvl & ~r_lvl_q;
   assign w_digit_ok = (bus.SW <= 4'd9);

   // Next-state and operand capture; Clr wins over a coincident accept.
   always_comb begin
      w_state_d = r_state;
      w_a_d     = r_a;
      w_b_d     = r_b;
      w_cin_d   = r_cin;
      w_err_d   = r_err;
      if (bus.Clr) begin
         w_state_d = StA;
         w_a_d     = 4'd0;
         w_b_d     = 4'd0;
         w_cin_d   = 1'b0;
         w_err_d   = 1'b0;
      end else if (w_accept) begin
         if (!w_digit_ok) begin
            w_err_d = 1'b1;
         end else begin
            w_err_d = 1'b0;
            unique case (r_state)
               StA: begin
                  w_a_d     = bus.SW;
                  w_state_d = StB;
               end
               StB: begin
                  w_b_d     = bus.SW;
                  w_cin_d   = bus.CinSw;
                  w_state_d = StDone;
               end
               StDone: begin
                  // A commit after a finished pair starts a fresh pair.
                  w_a_d     = bus.SW;
                  w_b_d     = 4'd0;
                  w_cin_d   = 1'b0;
                  w_state_d = StB;
               end
               default: begin
                  w_state_d = StA;
               end
            endcase
         end
      end
   end

   // State and operand registers.
   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         r_state <= StA;
         r_a     <= 4'd0;
         r_b     <= 4'd0;
         r_cin   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_a     <= w_a_d;
         r_b     <= w_b_d;
         r_cin   <= w_cin_d;
         r_err   <= w_err_d;
      end
   end

   assign bus.OPS   = {r_cin, r_a, r_b};
   assign bus.Valid = (r_state == StDone);
   assign bus.Err   = r_err;
   assign bus.Stage = r_state;

endmodule
